// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Definitions shared by the serial-adder datapath blocks:
//   - state_t         : converter FSM encodings (ST_IDLE, ST_CONV)
//   - BCD_ADJ_THRESH  : a BCD digit at or above this value is corrected before shifting
//   - BCD_ADJ_ADD     : correction added to such a digit
//   - SEG_0..SEG_9    : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK       : all segments off
//   - seg_decode()    : one BCD digit to an active-low pattern; 0xA-0xF show blank.
//                       Used only when SUM_BCD_SEVENSEG_EN is defined.
// -----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational shift-add-3 correction for one BCD digit: a digit of 5 or more
// gets 3 added, so that the following left shift carries into the next digit
// exactly when the doubled value reaches 10.
// Ports:
//   i_digit  in   4  scratch digit before the shift
//   o_digit  out  4  corrected digit (unsigned, 4-bit)
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import adder_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/sum_bcd_converter.sv
// -----------------------------------------------------------------------------
// sum_bcd_converter
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) sitting
// behind the serial adder. A one-cycle start in IDLE captures bin_in; N clocks
// later done pulses and bcd holds the packed result until the next done.
//
// Parameters:
//   N  binary input width (default 9)
//   D  BCD digit count; 10^D must exceed 2^N-1 (default 3)
//
// Ports:
//   clock   in   1    rising-edge clock
//   reset   in   1    synchronous, active-high; clears all state
//   start   in   1    conversion request, only honoured while busy=0
//   bin_in  in   N    binary value captured on the accepting edge
//   busy    out  1    high while converting
//   done    out  1    one-cycle pulse; bcd is valid from this cycle
//   bcd     out  4*D  packed BCD, digit 0 (units) in bcd[3:0]
//   hex_n   out  7*D  active-low {g..a} segments per digit; present only when
//                     SUM_BCD_SEVENSEG_EN is defined
//
// Build option: define SUM_BCD_SEVENSEG_EN to add the seven-segment decoder.
// -----------------------------------------------------------------------------
module sum_bcd_converter
    import adder_pkg::*;
#(
    parameter int N = 9,
    parameter int D = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   bin_in,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd
`ifdef SUM_BCD_SEVENSEG_EN
    ,
    output logic [7*D-1:0] hex_n
`endif
);

    localparam int CNT_W = $clog2(N + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_bin;
    logic [4*D-1:0]   r_scr;
    logic [CNT_W-1:0] r_cnt;
    logic [4*D-1:0]   r_bcd;
    logic             r_done;

    logic             w_accept;
    logic             w_conv;
    logic             w_last;
    logic [4*D-1:0]   w_scr_adj;
    logic [4*D-1:0]   w_scr_next;
    logic [N-1:0]     w_bin_next;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_conv   = (r_state == ST_CONV);
    assign w_last   = w_conv && (r_cnt == CNT_W'(1));

    // Correct every digit, then shift {scratch, bin} left by one as a whole.
    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_scr[4*g +: 4]),
            .o_digit (w_scr_adj[4*g +: 4])
        );
    end

    assign w_scr_next = {w_scr_adj[4*D-2:0], r_bin[N-1]};
    assign w_bin_next = {r_bin[N-2:0], 1'b0};

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_CONV;
            ST_CONV: if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == ST_CONV);
    end

`ifdef SUM_BCD_SEVENSEG_EN
    logic [7*D-1:0] r_hex_n;
    logic [7*D-1:0] w_hex_next;

    // Decoded from the same post-shift digits that are loaded into bcd.
    always_comb begin
        w_hex_next = '1;
        for (int i = 0; i < D; i++) begin
            w_hex_next[7*i +: 7] = seg_decode(w_scr_next[4*i +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hex_n <= '1;
        end else if (w_last) begin
            r_hex_n <= w_hex_next;
        end
    end

    assign hex_n = r_hex_n;
`endif

    // Conversion datapath; the result registers load only on the final step.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bin  <= '0;
            r_scr  <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin <= bin_in;
                r_scr <= '0;
                r_cnt <= CNT_W'(N);
            end else if (w_conv) begin
                r_bin <= w_bin_next;
                r_scr <= w_scr_next;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_bcd  <= w_scr_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: tb/tb_sum_bcd_converter.sv
module tb_sum_bcd_converter;
    import adder_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  bin_in = '0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef SUM_BCD_SEVENSEG_EN
    logic [20:0] hex_n;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sum_bcd_converter #(.N(9), .D(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
`ifdef SUM_BCD_SEVENSEG_EN
        ,
        .hex_n  (hex_n)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // single conversion: pulse start, wait for done, check latency/result/pulse width
    task automatic run(input logic [8:0] val, input logic [11:0] exp_bcd, input string tag);
        int lat;
        lat = 0;
        bin_in = val;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 9);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        step();
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int ndone;
        int lat1;
        int lat2;
        logic [11:0] bcd_at_done;

        // 1: reset in idle
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 12'h000);
`ifdef SUM_BCD_SEVENSEG_EN
        chk("rst_hex", hex_n, 21'h1FFFFF);
`endif
        step();

        // 2: zero
        run(9'd0, 12'h000, "zero");

        // 3: carries through the digit chain and the top of the range
        run(9'd255, 12'h255, "v255");
`ifdef SUM_BCD_SEVENSEG_EN
        chk("v255_hex0", hex_n[6:0], SEG_5);
        chk("v255_hex2", hex_n[20:14], SEG_2);
`endif
        run(9'd510, 12'h510, "v510");
`ifdef SUM_BCD_SEVENSEG_EN
        chk("v510_hex0", hex_n[6:0], SEG_0);
`endif
        run(9'd511, 12'h511, "v511");
`ifdef SUM_BCD_SEVENSEG_EN
        chk("v511_hex0", hex_n[6:0], SEG_1);
        chk("v511_hex1", hex_n[13:7], SEG_1);
`endif

        // 4: start while busy is ignored
        ndone = 0;
        lat1 = 0;
        bcd_at_done = '0;
        bin_in = 9'd123;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) begin
                bin_in = 9'd45;
                start  = 1'b1;
            end
            if (k == 5) start = 1'b0;
            step();
            if (done) begin
                ndone++;
                lat1 = k;
                bcd_at_done = bcd;
            end
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_lat", lat1, 9);
        chk("busy_start_bcd", bcd_at_done, 12'h123);
        chk("busy_start_idle", busy, 0);

        // 5: reset aborts a conversion
        ndone = 0;
        bin_in = 9'd300;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) reset = 1'b1;
            if (k == 5) reset = 1'b0;
            step();
            if (done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        chk("abort_bcd", bcd, 12'h000);
        chk("abort_busy", busy, 0);
`ifdef SUM_BCD_SEVENSEG_EN
        chk("abort_hex", hex_n, 21'h1FFFFF);
`endif
        run(9'd7, 12'h007, "v7");

        // 6: start held in the done cycle is accepted back-to-back
        lat1 = 0;
        lat2 = 0;
        bin_in = 9'd99;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 11) start = 1'b0;
            step();
            if (done && lat1 == 0) begin
                lat1 = k;
                chk("b2b_first_bcd", bcd, 12'h099);
                bin_in = 9'd400;
                start  = 1'b1;
            end else if (done && lat1 != 0) begin
                lat2 = k;
                chk("b2b_second_bcd", bcd, 12'h400);
                break;
            end
            if (k == 15) chk("b2b_hold_bcd", bcd, 12'h099);
            if (k == 10) chk("b2b_busy_again", busy, 1);
        end
        start = 1'b0;
        chk("b2b_first_lat", lat1, 9);
        chk("b2b_second_lat", lat2 - lat1, 10);
`ifdef SUM_BCD_SEVENSEG_EN
        chk("b2b_hex0", hex_n[6:0], SEG_0);
        chk("b2b_hex2", hex_n[20:14], SEG_4);
`endif
        step();
        chk("b2b_done_width", done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
